// File: rtl/kronos_pkg.sv
// Shared types and constants for the kronos issue scheduler and permutation datapath.
package kronos_pkg;

  localparam int SCHED_ID_W = 4;
  localparam int SCHED_OP_W = 2;

  localparam logic [SCHED_OP_W-1:0] KRONOS_OP_ROTL = 2'd0;
  localparam logic [SCHED_OP_W-1:0] KRONOS_OP_ROTR = 2'd1;
  localparam logic [SCHED_OP_W-1:0] KRONOS_OP_REV  = 2'd2;
  localparam logic [SCHED_OP_W-1:0] KRONOS_OP_SWAP = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } sched_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  committed;
    logic                  killed;
    logic [SCHED_ID_W-1:0] id;
    logic [4:0]            rd;
    logic [SCHED_OP_W-1:0] op;
    logic                  we;
  } sched_entry_t;

endpackage

// File: rtl/kronos_sched_table.sv
// In-order slot table: circular FIFO of issued instructions with a parallel commit-id match.
module kronos_sched_table
  import kronos_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = SCHED_ID_W,
  parameter int OP_W  = SCHED_OP_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [ID_W-1:0]  issue_id_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic             issue_we_i,
  input  logic             commit_valid_i,
  input  logic [ID_W-1:0]  commit_id_i,
  input  logic             commit_kill_i,
  input  logic             pop_i,
  output sched_entry_t     head_o,
  output logic [PTR_W:0]   count_o
);

  sched_entry_t     r_slot [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_new_match;
  sched_entry_t     w_new;

  // A commit racing the issue of the same id must land on the slot being written.
  assign w_new_match = commit_valid_i && (commit_id_i == issue_id_i);

  always_comb begin
    w_new           = '0;
    w_new.valid     = 1'b1;
    w_new.committed = w_new_match;
    w_new.killed    = w_new_match && commit_kill_i;
    w_new.id        = SCHED_ID_W'(issue_id_i);
    w_new.rd        = issue_rd_i;
    w_new.op        = SCHED_OP_W'(issue_op_i);
    w_new.we        = issue_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (r_tail == PTR_W'(i))) begin
          r_slot[i] <= w_new;
        end else if (pop_i && (r_head == PTR_W'(i))) begin
          r_slot[i].valid <= 1'b0;
        end else if (commit_valid_i && r_slot[i].valid && !r_slot[i].committed &&
                     (r_slot[i].id == SCHED_ID_W'(commit_id_i))) begin
          r_slot[i].committed <= 1'b1;
          r_slot[i].killed    <= commit_kill_i;
        end
      end
      if (push_i) r_tail <= r_tail + 1'b1;
      if (pop_i)  r_head <= r_head + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_slot[r_head];
  assign count_o = r_count;

endmodule

// File: rtl/kronos_issue_sched.sv
// Issue scheduler: launches committed instructions on the kronos datapath and returns results in order.
// Optional macro KRONOS_SCHED_PERF_EN adds saturating issue/kill/stall counters.
module kronos_issue_sched
  import kronos_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int OP_W  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [ID_W-1:0]  issue_id_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic             issue_we_i,
  input  logic             commit_valid_i,
  input  logic [ID_W-1:0]  commit_id_i,
  input  logic             commit_kill_i,
  output logic             dp_start_o,
  output logic [OP_W-1:0]  dp_op_o,
  input  logic             dp_done_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [ID_W-1:0]  result_id_o,
  output logic [4:0]       result_rd_o,
  output logic             result_we_o,
  output logic             busy_o
`ifdef KRONOS_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_issued_o,
  output logic [31:0]      perf_killed_o,
  output logic [31:0]      perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  sched_state_e   r_state;
  sched_entry_t   w_head;
  logic [PTR_W:0] w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_head_kill;
  logic           w_head_go;
  logic           r_dp_start;
  logic [OP_W-1:0] r_dp_op;
  logic           r_result_valid;
  logic [ID_W-1:0] r_result_id;
  logic [4:0]     r_result_rd;
  logic           r_result_we;

  assign issue_ready_o = w_count < (PTR_W+1)'(DEPTH);
  assign w_push        = issue_valid_i && issue_ready_o;
  assign w_head_kill   = (r_state == IDLE) && w_head.valid && w_head.committed && w_head.killed;
  assign w_head_go     = (r_state == IDLE) && w_head.valid && w_head.committed && !w_head.killed;
  assign w_pop         = w_head_kill || ((r_state == RESP) && result_ready_i);

  kronos_sched_table #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .OP_W  (OP_W)
  ) u_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (w_push),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .issue_op_i     (issue_op_i),
    .issue_we_i     (issue_we_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .pop_i          (w_pop),
    .head_o         (w_head),
    .count_o        (w_count)
  );

  // The launch pulse is raised on entry to START so it coincides with that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_dp_start     <= 1'b0;
      r_dp_op        <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
      r_result_rd    <= '0;
      r_result_we    <= 1'b0;
    end else begin
      r_dp_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_head_go) begin
            r_state    <= START;
            r_dp_start <= 1'b1;
            r_dp_op    <= OP_W'(w_head.op);
          end
        end
        START: r_state <= BUSY;
        BUSY: begin
          if (dp_done_i) begin
            r_state        <= RESP;
            r_result_valid <= 1'b1;
            r_result_id    <= ID_W'(w_head.id);
            r_result_rd    <= w_head.rd;
            r_result_we    <= w_head.we;
          end
        end
        RESP: begin
          if (result_ready_i) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dp_start_o     = r_dp_start;
  assign dp_op_o        = r_dp_op;
  assign result_valid_o = r_result_valid;
  assign result_id_o    = r_result_id;
  assign result_rd_o    = r_result_rd;
  assign result_we_o    = r_result_we;
  assign busy_o         = (w_count != '0) || (r_state != IDLE);

`ifdef KRONOS_SCHED_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_killed;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_issued <= '0;
      r_perf_killed <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_push && (r_perf_issued != '1)) r_perf_issued <= r_perf_issued + 32'd1;
      if (w_head_kill && (r_perf_killed != '1)) r_perf_killed <= r_perf_killed + 32'd1;
      if (issue_valid_i && !issue_ready_o && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued_o = r_perf_issued;
  assign perf_killed_o = r_perf_killed;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_kronos_issue_sched.sv
// Scoreboard bench for kronos_issue_sched: directed issue/commit vectors, monitor-side checking.
`timescale 1ns/1ps
module tb_kronos_issue_sched;
  import kronos_pkg::*;

  localparam int ID_W = 4;
  localparam int OP_W = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic            we;
  } expRes_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic [ID_W-1:0] issue_id_i = '0;
  logic [4:0]      issue_rd_i = '0;
  logic [OP_W-1:0] issue_op_i = '0;
  logic            issue_we_i = 1'b0;
  logic            commit_valid_i = 1'b0;
  logic [ID_W-1:0] commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            dp_start_o;
  logic [OP_W-1:0] dp_op_o;
  logic            dp_done_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b1;
  logic [ID_W-1:0] result_id_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;
  logic            busy_o;
`ifdef KRONOS_SCHED_PERF_EN
  logic [31:0]     perfIssued;
  logic [31:0]     perfKilled;
  logic [31:0]     perfStall;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCount = 0;
  int lastStartCyc = 0;
  int lastDoneCyc = 0;
  int commitCyc = 0;
  int dpCnt = 0;
  logic prevValid = 1'b0;

  logic [OP_W-1:0] expStartQ[$];
  expRes_t         expResQ[$];

  kronos_issue_sched #(.DEPTH(4), .ID_W(ID_W), .OP_W(OP_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .issue_op_i     (issue_op_i),
    .issue_we_i     (issue_we_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .dp_start_o     (dp_start_o),
    .dp_op_o        (dp_op_o),
    .dp_done_i      (dp_done_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_we_o    (result_we_o),
    .busy_o         (busy_o)
`ifdef KRONOS_SCHED_PERF_EN
    ,
    .perf_issued_o  (perfIssued),
    .perf_killed_o  (perfKilled),
    .perf_stall_o   (perfStall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [OP_W-1:0] op, input logic [ID_W-1:0] id,
                              input logic [4:0] rd, input logic we);
    expRes_t r;
    r.id = id;
    r.rd = rd;
    r.we = we;
    expStartQ.push_back(op);
    expResQ.push_back(r);
  endtask

  // One cycle of issue/commit stimulus, driven at the falling edge and released after the rising edge.
  task automatic applyStimulus(input logic iv, input logic [ID_W-1:0] id, input logic [4:0] rd,
                               input logic [OP_W-1:0] op, input logic we,
                               input logic cv, input logic [ID_W-1:0] cid, input logic kill);
    @(negedge clk);
    issue_valid_i  = iv;
    issue_id_i     = id;
    issue_rd_i     = rd;
    issue_op_i     = op;
    issue_we_i     = we;
    commit_valid_i = cv;
    commit_id_i    = cid;
    commit_kill_i  = kill;
    if (cv) commitCyc = cyc;
    @(posedge clk);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic issueInstr(input logic [ID_W-1:0] id, input logic [4:0] rd,
                            input logic [OP_W-1:0] op, input logic we);
    applyStimulus(1'b1, id, rd, op, we, 1'b0, '0, 1'b0);
  endtask

  task automatic commitInstr(input logic [ID_W-1:0] id, input logic kill);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, id, kill);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((busy_o || expResQ.size() != 0 || expStartQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drainTimeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Datapath model: done pulse four cycles after each launch; lost on reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      dpCnt     = 0;
      dp_done_i = 1'b0;
    end else begin
      dp_done_i = 1'b0;
      if (dpCnt > 0) begin
        dpCnt--;
        if (dpCnt == 0) begin
          dp_done_i   = 1'b1;
          lastDoneCyc = cyc;
        end
      end
      if (dp_start_o) dpCnt = 4;
    end
  end

  // Monitor: pops the scoreboard on every launch and every accepted result.
  always @(negedge clk) begin
    expRes_t r;
    logic [OP_W-1:0] op;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (dp_start_o) begin
        startCount++;
        lastStartCyc = cyc;
        if (expStartQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedStart: got dp_start_o=1 op=%0d expected no launch", dp_op_o);
        end else begin
          op = expStartQ.pop_front();
          checkOutput("dpOp", 32'(dp_op_o), 32'(op));
        end
      end
      if (result_valid_o && !prevValid)
        checkOutput("resultLatency", cyc, lastDoneCyc + 1);
      if (result_valid_o && result_ready_i) begin
        if (expResQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedResult: got id=%0d expected no result", result_id_o);
        end else begin
          r = expResQ.pop_front();
          checkOutput("resultId", 32'(result_id_o), 32'(r.id));
          checkOutput("resultRd", 32'(result_rd_o), 32'(r.rd));
          checkOutput("resultWe", 32'(result_we_o), 32'(r.we));
        end
      end
      prevValid = result_valid_o;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int n;
`ifdef KRONOS_SCHED_PERF_EN
    logic [31:0] stall0;
    logic [31:0] killed0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstIssueReady", 32'(issue_ready_o), 32'd1);
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstDpStart", 32'(dp_start_o), 32'd0);
    checkOutput("rstResultValid", 32'(result_valid_o), 32'd0);
    checkOutput("rstDpOp", 32'(dp_op_o), 32'd0);
    checkOutput("rstResultFields", {result_id_o, result_rd_o, result_we_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstIssueReady", 32'(issue_ready_o), 32'd1);

    // Test 1: basic launch and latency
    pushExpected(KRONOS_OP_ROTR, 4'd3, 5'd7, 1'b1);
    issueInstr(4'd3, 5'd7, KRONOS_OP_ROTR, 1'b1);
    commitInstr(4'd3, 1'b0);
    waitIdle("t1", 100);
    checkOutput("t1StartLatency", lastStartCyc, commitCyc + 2);

    // Test 2: fill all slots, fifth issue stalls
    issueInstr(4'd1, 5'd11, KRONOS_OP_ROTL, 1'b1);
    issueInstr(4'd2, 5'd12, KRONOS_OP_ROTR, 1'b0);
    issueInstr(4'd3, 5'd13, KRONOS_OP_REV, 1'b1);
    issueInstr(4'd4, 5'd14, KRONOS_OP_SWAP, 1'b0);
    @(negedge clk);
    checkOutput("t2FullReady", 32'(issue_ready_o), 32'd0);
`ifdef KRONOS_SCHED_PERF_EN
    stall0 = perfStall;
`endif
    issueInstr(4'd5, 5'd15, KRONOS_OP_REV, 1'b1);
    @(negedge clk);
    checkOutput("t2StillFull", 32'(issue_ready_o), 32'd0);
`ifdef KRONOS_SCHED_PERF_EN
    checkOutput("t2StallCount", perfStall, stall0 + 32'd1);
`endif
    pushExpected(KRONOS_OP_ROTL, 4'd1, 5'd11, 1'b1);
    pushExpected(KRONOS_OP_ROTR, 4'd2, 5'd12, 1'b0);
    pushExpected(KRONOS_OP_REV,  4'd3, 5'd13, 1'b1);
    pushExpected(KRONOS_OP_SWAP, 4'd4, 5'd14, 1'b0);
    s0 = startCount;
    commitInstr(4'd1, 1'b0);
    commitInstr(4'd2, 1'b0);
    commitInstr(4'd3, 1'b0);
    commitInstr(4'd4, 1'b0);
    waitIdle("t2", 200);
    checkOutput("t2Starts", startCount - s0, 32'd4);

    // Test 3: killed instruction is dropped
`ifdef KRONOS_SCHED_PERF_EN
    killed0 = perfKilled;
`endif
    issueInstr(4'd5, 5'd9, KRONOS_OP_REV, 1'b1);
    issueInstr(4'd6, 5'd10, KRONOS_OP_SWAP, 1'b0);
    pushExpected(KRONOS_OP_SWAP, 4'd6, 5'd10, 1'b0);
    s0 = startCount;
    commitInstr(4'd5, 1'b1);
    commitInstr(4'd6, 1'b0);
    waitIdle("t3", 100);
    checkOutput("t3Starts", startCount - s0, 32'd1);
`ifdef KRONOS_SCHED_PERF_EN
    checkOutput("t3KilledCount", perfKilled, killed0 + 32'd1);
`endif

    // Test 4: younger commit waits for the head
    issueInstr(4'd5, 5'd20, KRONOS_OP_ROTR, 1'b1);
    issueInstr(4'd6, 5'd21, KRONOS_OP_REV, 1'b1);
    pushExpected(KRONOS_OP_ROTR, 4'd5, 5'd20, 1'b1);
    pushExpected(KRONOS_OP_REV,  4'd6, 5'd21, 1'b1);
    s0 = startCount;
    commitInstr(4'd6, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("t4NoLaunch", startCount - s0, 32'd0);
    checkOutput("t4NoResult", 32'(result_valid_o), 32'd0);
    commitInstr(4'd5, 1'b0);
    waitIdle("t4", 100);
    checkOutput("t4Starts", startCount - s0, 32'd2);

    // Test 5: result held stable under backpressure
    result_ready_i = 1'b0;
    issueInstr(4'd9, 5'd3, KRONOS_OP_ROTL, 1'b1);
    pushExpected(KRONOS_OP_ROTL, 4'd9, 5'd3, 1'b1);
    commitInstr(4'd9, 1'b0);
    n = 0;
    while (!result_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5ValidTimeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checkOutput("t5HoldValid", 32'(result_valid_o), 32'd1);
      checkOutput("t5HoldId", 32'(result_id_o), 32'd9);
      checkOutput("t5HoldRd", 32'(result_rd_o), 32'd3);
      checkOutput("t5HoldWe", 32'(result_we_o), 32'd1);
    end
    @(posedge clk);
    #1;
    result_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("t5PopValid", 32'(result_valid_o), 32'd0);
    checkOutput("t5PopBusy", 32'(busy_o), 32'd0);
    waitIdle("t5", 20);

    // Test 6: reset while the datapath is busy
    issueInstr(4'd2, 5'd4, KRONOS_OP_SWAP, 1'b1);
    pushExpected(KRONOS_OP_SWAP, 4'd2, 5'd4, 1'b1);
    s0 = startCount;
    commitInstr(4'd2, 1'b0);
    n = 0;
    while (startCount == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6StartTimeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expStartQ.delete();
    expResQ.delete();
    checkOutput("t6RstBusy", 32'(busy_o), 32'd0);
    checkOutput("t6RstDpStart", 32'(dp_start_o), 32'd0);
    checkOutput("t6RstDpOp", 32'(dp_op_o), 32'd0);
    checkOutput("t6RstResultValid", 32'(result_valid_o), 32'd0);
    checkOutput("t6RstResultFields", {result_id_o, result_rd_o, result_we_o}, 32'd0);
    checkOutput("t6RstIssueReady", 32'(issue_ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t6NoStaleResult", 32'(result_valid_o), 32'd0);
    checkOutput("t6ReadyAfter", 32'(issue_ready_o), 32'd1);
    issueInstr(4'd7, 5'd1, KRONOS_OP_ROTR, 1'b0);
    pushExpected(KRONOS_OP_ROTR, 4'd7, 5'd1, 1'b0);
    commitInstr(4'd7, 1'b0);
    waitIdle("t6", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
